// File: rtl/filt_seq_pkg.sv
// Shared constants and state encoding for the image-filter sweep sequencer.
// FSEQ_STEP_EN (optional define) gates RUN-state issues on a step pulse.
package filt_seq_pkg;

  // Defaults shared with the src/dst meminferida instantiations.
  localparam int DEFAULT_ADDR_BITS = 10;
  localparam int PIX_WIDTH         = 24;
  localparam int FILTER_LAT_MAX    = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } seq_state_e;

endpackage

// File: rtl/filt_seq_ctrl_if.sv
// Control/status bundle between the top-level control logic and the sweep sequencer.
// The master side drives the sweep request; the slave side is the sequencer.
interface filt_seq_ctrl_if
  import filt_seq_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
);

  logic                 start;
  logic [ADDR_BITS-1:0] last_addr;
  logic                 stall;
  logic                 step;
  logic [ADDR_BITS-1:0] src_addr;
  logic [ADDR_BITS-1:0] dst_addr;
  logic                 dst_we;
  logic                 busy;
  logic                 done;

  modport master (
    output start, last_addr, stall, step,
    input  src_addr, dst_addr, dst_we, busy, done
  );

  modport slave (
    input  start, last_addr, stall, step,
    output src_addr, dst_addr, dst_we, busy, done
  );

endinterface

// File: rtl/filt_seq_ctrl_seq_delay_line.sv
// Fixed-depth shift register used to carry {valid, addr} alongside the RAM read
// and filter pipeline so the dst write lands on the matching address.
module seq_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: every stage is reset (it is only a few flops) so a mid-sweep reset
  // clears all in-flight valid bits at once instead of draining stale writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/filt_seq_ctrl.sv
// Start/done sequencer: src RAM read -> FILTER_LAT filter -> dst RAM write, one pixel per cycle.
// Define FSEQ_STEP_EN to issue only on step pulses (single-step debug).
module filt_seq_ctrl
  import filt_seq_pkg::*;
#(
  parameter int ADDR_BITS  = DEFAULT_ADDR_BITS,
  parameter int FILTER_LAT = 1
) (
  input logic            clk,
  input logic            reset,
  filt_seq_ctrl_if.slave bus
);

  // One stage for the synchronous src read plus one per filter stage.
  localparam int PIPE_DEPTH = 1 + FILTER_LAT;
  localparam int PIPE_WIDTH = 1 + ADDR_BITS;

  seq_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0] src_addr_q, src_addr_d;
  logic [ADDR_BITS-1:0] last_q, last_d;
  logic                 step_ok;
  logic                 issue_v;
  logic                 at_last;
  logic [PIPE_WIDTH-1:0] pipe_out;
  logic                 pipe_valid;
  logic [ADDR_BITS-1:0] pipe_addr;

`ifdef FSEQ_STEP_EN
  assign step_ok = bus.step;
`else
  assign step_ok = 1'b1;
`endif

  assign issue_v = (state_q == S_RUN) && !bus.stall && step_ok;
  assign at_last = (src_addr_q == last_q);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    src_addr_d = src_addr_q;
    last_d     = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          last_d     = bus.last_addr;
          src_addr_d = '0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        // The final address parks in src_addr so a full-RAM sweep never wraps.
        if (issue_v) begin
          if (at_last) state_d = S_DRAIN;
          else         src_addr_d = src_addr_q + ADDR_BITS'(1);
        end
      end
      S_DRAIN: begin
        // Addresses leave the pipe in issue order, so the last address is the last write.
        if (pipe_valid && (pipe_addr == last_q)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      src_addr_q <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      src_addr_q <= src_addr_d;
      last_q     <= last_d;
    end
  end

  seq_delay_line #(
    .DEPTH (PIPE_DEPTH),
    .WIDTH (PIPE_WIDTH)
  ) u_pipe (
    .clk   (clk),
    .reset (reset),
    .din   ({issue_v, src_addr_q}),
    .dout  (pipe_out)
  );

  assign pipe_valid = pipe_out[PIPE_WIDTH-1];
  assign pipe_addr  = pipe_out[ADDR_BITS-1:0];

  assign bus.src_addr = src_addr_q;
  assign bus.dst_addr = pipe_addr;
  assign bus.dst_we   = pipe_valid;
  assign bus.busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done     = (state_q == S_DONE);

endmodule

// File: tb/tb_filt_seq_ctrl.sv
// Directed bench for filt_seq_ctrl: instance A has FILTER_LAT=1, instance B FILTER_LAT=0.
// Write/done/busy events are logged on the falling edge and compared as offsets from the first RUN cycle.
module tb_filt_seq_ctrl;
  import filt_seq_pkg::*;

  localparam int AB  = 10;
  localparam int BAD = 99999;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  filt_seq_ctrl_if #(.ADDR_BITS(AB)) bus_a ();
  filt_seq_ctrl_if #(.ADDR_BITS(AB)) bus_b ();

  filt_seq_ctrl #(.ADDR_BITS(AB), .FILTER_LAT(1)) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  filt_seq_ctrl #(.ADDR_BITS(AB), .FILTER_LAT(0)) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event logs
  int   wa_addr[$], wa_cyc[$], da_cyc[$], ba_cyc[$];
  int   wb_addr[$], wb_cyc[$], db_cyc[$], bb_cyc[$];
  int   a_zero_cnt = 0;
  logic a_busy_prev = 1'b0;
  logic b_busy_prev = 1'b0;
  int   exp_off[$];

  always @(negedge clk) begin
    if (bus_a.dst_we === 1'b1) begin wa_addr.push_back(int'(bus_a.dst_addr)); wa_cyc.push_back(cyc); end
    if (bus_a.done === 1'b1) da_cyc.push_back(cyc);
    if (bus_a.busy === 1'b1 && !a_busy_prev) ba_cyc.push_back(cyc);
    if (bus_a.busy === 1'b1 && bus_a.src_addr == '0) a_zero_cnt++;
    a_busy_prev = (bus_a.busy === 1'b1);
    if (bus_b.dst_we === 1'b1) begin wb_addr.push_back(int'(bus_b.dst_addr)); wb_cyc.push_back(cyc); end
    if (bus_b.done === 1'b1) db_cyc.push_back(cyc);
    if (bus_b.busy === 1'b1 && !b_busy_prev) bb_cyc.push_back(cyc);
    b_busy_prev = (bus_b.busy === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_a();
    wa_addr.delete(); wa_cyc.delete(); da_cyc.delete(); ba_cyc.delete();
    a_zero_cnt = 0;
  endtask

  task automatic fill_linear(input int n, input int lat);
    exp_off.delete();
    for (int i = 0; i < n; i++) exp_off.push_back(1 + lat + i);
  endtask

  // Leaves the caller inside the first RUN cycle.
  task automatic start_a(input int last);
    bus_a.last_addr = AB'(last);
    bus_a.start     = 1'b1;
    tick();
    bus_a.start     = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    int k;
    k = 0;
    while (da_cyc.size() == 0 && k < budget) begin tick(); k++; end
    check({tag, " done_seen"}, da_cyc.size(), 1);
  endtask

  // Writes must be addresses 0..n-1 in order at the offsets held in exp_off.
  task automatic check_sweep_a(input string tag, input int n, input int done_off);
    int r0, bad;
    r0  = (ba_cyc.size() > 0) ? ba_cyc[0] : 0;
    bad = BAD;
    check({tag, " write_count"}, wa_addr.size(), n);
    for (int i = 0; i < wa_addr.size() && i < exp_off.size(); i++)
      if (bad == BAD && (wa_addr[i] != i || wa_cyc[i] - r0 != exp_off[i])) bad = i;
    check({tag, " first_bad_write"}, bad, BAD);
    check({tag, " done_offset"}, (da_cyc.size() > 0) ? da_cyc[0] - r0 : BAD, done_off);
    check({tag, " busy_rises"}, ba_cyc.size(), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, r0, last_i;
    bus_a.start = 1'b0; bus_a.last_addr = '0; bus_a.stall = 1'b0; bus_a.step = 1'b1;
    bus_b.start = 1'b0; bus_b.last_addr = '0; bus_b.stall = 1'b0; bus_b.step = 1'b1;

    // Reset state
    tick(2);
    check("rst src_addr", bus_a.src_addr, 0);
    check("rst dst_addr", bus_a.dst_addr, 0);
    check("rst dst_we",   bus_a.dst_we,   0);
    check("rst busy",     bus_a.busy,     0);
    check("rst done",     bus_a.done,     0);
    reset = 1'b1;
    tick(2);

    // Basic sweep of 4; last_addr change and a start pulse mid-sweep must be ignored
    clear_a();
    start_a(3);
    bus_a.last_addr = AB'(9);
    tick(2);
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    wait_done_a("t1", 50);
    fill_linear(4, 1);
    check_sweep_a("t1", 4, 6);
    check("t1 busy_after", bus_a.busy, 0);
    check("t1 done_after", bus_a.done, 0);
    tick(4);
    check("t1 no_restart_writes", wa_addr.size(), 4);

    // Two-cycle stall after address 2 is issued
    clear_a();
    start_a(5);
    tick(3);
    bus_a.stall = 1'b1;
    tick(2);
    bus_a.stall = 1'b0;
    wait_done_a("t2", 50);
    exp_off.delete();
    exp_off.push_back(2); exp_off.push_back(3); exp_off.push_back(4);
    exp_off.push_back(7); exp_off.push_back(8); exp_off.push_back(9);
    check_sweep_a("t2", 6, 10);
    tick(2);

    // Stall on the last-issue cycle, then stall held through DRAIN
    clear_a();
    start_a(2);
    tick(2);
    bus_a.stall = 1'b1;
    tick();
    bus_a.stall = 1'b0;
    tick();
    bus_a.stall = 1'b1;
    wait_done_a("t2b", 50);
    exp_off.delete();
    exp_off.push_back(2); exp_off.push_back(3); exp_off.push_back(5);
    check_sweep_a("t2b", 3, 6);
    tick(2);
    bus_a.stall = 1'b0;

    // Single pixel on the combinational-filter instance
    wb_addr.delete(); wb_cyc.delete(); db_cyc.delete(); bb_cyc.delete();
    bus_b.last_addr = '0;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    k = 0;
    while (db_cyc.size() == 0 && k < 20) begin tick(); k++; end
    r0 = (bb_cyc.size() > 0) ? bb_cyc[0] : 0;
    check("t3 write_count", wb_addr.size(), 1);
    check("t3 write_addr",  (wb_addr.size() > 0) ? wb_addr[0] : BAD, 0);
    check("t3 write_offset", (wb_cyc.size() > 0) ? wb_cyc[0] - r0 : BAD, 1);
    check("t3 done_offset", (db_cyc.size() > 0) ? db_cyc[0] - r0 : BAD, 2);
    tick(2);

    // start held high through DONE: second sweep accepted in the first IDLE cycle
    clear_a();
    bus_a.last_addr = AB'(1);
    bus_a.start = 1'b1;
    tick();
    bus_a.last_addr = '0;
    k = 0;
    while (ba_cyc.size() < 2 && k < 40) begin tick(); k++; end
    bus_a.start = 1'b0;
    k = 0;
    while (da_cyc.size() < 2 && k < 40) begin tick(); k++; end
    r0 = (ba_cyc.size() > 0) ? ba_cyc[0] : 0;
    check("thold busy_rises", ba_cyc.size(), 2);
    check("thold second_start", (ba_cyc.size() > 1) ? ba_cyc[1] - r0 : BAD, 6);
    check("thold write_count", wa_addr.size(), 3);
    check("thold addr1", (wa_addr.size() > 1) ? wa_addr[1] : BAD, 1);
    check("thold addr2", (wa_addr.size() > 2) ? wa_addr[2] : BAD, 0);
    check("thold write2_offset", (wa_cyc.size() > 2) ? wa_cyc[2] - r0 : BAD, 8);
    check("thold done1_offset", (da_cyc.size() > 0) ? da_cyc[0] - r0 : BAD, 4);
    check("thold done2_offset", (da_cyc.size() > 1) ? da_cyc[1] - r0 : BAD, 9);
    tick(2);

    // Full RAM sweep: 1024 writes, no wrap of src_addr
    clear_a();
    start_a(1023);
    wait_done_a("t4", 1100);
    fill_linear(1024, 1);
    check_sweep_a("t4", 1024, 1026);
    r0     = (ba_cyc.size() > 0) ? ba_cyc[0] : 0;
    last_i = wa_cyc.size() - 1;
    check("t4 last_write_offset", (last_i >= 0) ? wa_cyc[last_i] - r0 : BAD, 1025);
    check("t4 src_zero_cycles", a_zero_cnt, 1);
    check("t4 src_addr_parked", bus_a.src_addr, 1023);
    tick(2);

    // Asynchronous reset in the middle of a sweep
    clear_a();
    start_a(20);
    tick(7);
    check("t5 src_before_reset", bus_a.src_addr, 7);
    check("t5 we_before_reset",  bus_a.dst_we, 1);
    check("t5 addr_before_reset", bus_a.dst_addr, 5);
    reset = 1'b0;
    #1;
    check("t5 rst dst_we",   bus_a.dst_we,   0);
    check("t5 rst busy",     bus_a.busy,     0);
    check("t5 rst src_addr", bus_a.src_addr, 0);
    check("t5 rst done",     bus_a.done,     0);
    #2;
    reset = 1'b1;
    tick(2);
    clear_a();
    start_a(2);
    wait_done_a("t5", 50);
    fill_linear(3, 1);
    check_sweep_a("t5", 3, 5);
    tick(2);

`ifdef FSEQ_STEP_EN
    // One issue per step pulse; a start during the sweep is ignored
    bus_a.step = 1'b0;
    clear_a();
    bus_a.step = 1'b1;
    start_a(2);
    for (int p = 0; p < 3; p++) begin
      bus_a.step = 1'b1;
      tick();
      bus_a.step = 1'b0;
      if (p == 0) begin
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        tick(2);
      end else begin
        tick(3);
      end
    end
    wait_done_a("t6", 50);
    exp_off.delete();
    exp_off.push_back(2); exp_off.push_back(6); exp_off.push_back(10);
    check_sweep_a("t6", 3, 11);
    bus_a.step = 1'b1;
`else
    // step is ignored: holding it low must not slow the sweep
    bus_a.step = 1'b0;
    clear_a();
    start_a(2);
    wait_done_a("t6", 50);
    fill_linear(3, 1);
    check_sweep_a("t6", 3, 5);
    bus_a.step = 1'b1;
`endif
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/filt_seq_ctrl.md
Name: filt_seq_ctrl

Overview:
- Sequencer for the image-filter datapath: src RAM (sync read, 1-cycle latency) -> filter pipeline (FILTER_LAT cycles) -> dst RAM (sync write).
- Replaces the free-running read/filter/write loop with a start/done-controlled, fully pipelined sweep of one pixel per cycle.
- Drives a shared address to src and a delayed, aligned address plus write enable to dst.
- Sits between the top-level control (buttons/display) and the two meminferida instances.

Parameters:
ADDR_BITS, 10, RAM address width (both RAMs)
FILTER_LAT, 1, filter pipeline latency in cycles; 0 = combinational filter; legal 0..7

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin a sweep; sampled only in IDLE
last_addr  input  ADDR_BITS  final pixel address of the sweep, inclusive; latched on accepted start
stall  input  1  suppress new reads while high; in-flight pixels keep draining
step  input  1  single-step pulse (used only with FSEQ_STEP_EN)
src_addr  output  ADDR_BITS  src RAM read address (registered)
dst_addr  output  ADDR_BITS  dst RAM write address, aligned with filter output
dst_we  output  1  dst RAM write enable
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse when the last write has completed

Behaviour:
- Reset (reset=0, async): state=IDLE; src_addr=0; dst_addr=0; dst_we=0; busy=0; done=0; last-addr latch=0; all pipe valid bits=0. Takes effect immediately mid-sweep, with no partial flush.
- States: IDLE, RUN, DRAIN, DONE; 2-bit encoding 00/01/10/11.
- IDLE:
  - start=1: latch last_addr, src_addr<=0, go to RUN.
  - Otherwise hold; start is ignored in every other state.
- RUN:
  - Each cycle with stall=0 is an issue cycle: issue_v=1 and the current src_addr is issued.
  - If src_addr==latched last, go to DRAIN next cycle with src_addr unchanged (no wrap to 0). Otherwise src_addr<=src_addr+1.
  - stall=1: issue_v=0 and src_addr holds.
- DRAIN: no issues; go to DONE on the cycle after the final dst_we=1.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Alignment: a pixel issued at cycle t (src_addr=A, issue_v=1) produces dst_we=1 and dst_addr=A at cycle t+1+FILTER_LAT.
- Implementation: a (1+FILTER_LAT)-deep shift register carrying {valid, addr}; dst_we = valid of the last stage.
- Throughput: 1 pixel/cycle with stall=0. Total sweep with no stalls = N + 1 + FILTER_LAT cycles from first RUN cycle to last write, N = last+1.
- Boundaries:
  - last_addr=0: single pixel.
  - last_addr=2^ADDR_BITS-1: full RAM, no counter overflow.
  - stall asserted on the last-issue cycle: that issue is delayed, not lost.
  - stall in DRAIN/IDLE: no effect.
  - start held high through DONE: new sweep starts on the first IDLE cycle.
- dst_we is never 1 for an address that was not issued; each address is written exactly once per sweep.

Optional Feature:
- FSEQ_STEP_EN defined:
  - In RUN, an issue occurs only on a cycle where step=1 and stall=0, so one pixel per step pulse.
  - step is level-sampled; the driver supplies single-cycle pulses.
- Not defined: step is ignored and issue follows stall only.

Decomposition:
- Package filt_seq_pkg:
  - State localparams S_IDLE=2'b00, S_RUN=2'b01, S_DRAIN=2'b10, S_DONE=2'b11.
  - Default ADDR_BITS=10 and PIX_WIDTH=24 constants shared with meminferida instantiation.
- One sub-module, seq_delay_line: parameterized DEPTH/WIDTH shift register with async active-low reset, used for the {valid, addr} pipe.

Test Plan:
1. FILTER_LAT=1, last_addr=3, start pulse, no stall -> src_addr 0,1,2,3 on consecutive RUN cycles; dst_we=1 with dst_addr 0..3 starting 2 cycles after first issue; done pulse 1 cycle after the addr-3 write; busy low again.
2. last_addr=5, stall=1 for 2 cycles after addr 2 issued -> dst_addr sequence 0..5 each exactly once with a 2-cycle dst_we gap; done 2 cycles later than the no-stall case.
3. last_addr=0, FILTER_LAT=0 -> single write to addr 0 one cycle after issue; done next cycle.
4. last_addr=1023 -> 1024 writes; src_addr stops at 1023 (never 0 after start); total 1024+1+FILTER_LAT cycles to last write.
5. reset=0 asserted mid-RUN at addr 7 -> same-cycle dst_we=0, busy=0, state IDLE; fresh start restarts from addr 0.
6. FSEQ_STEP_EN, last_addr=2, step pulses every 4 cycles -> one dst write per pulse at 1+FILTER_LAT after the pulse; start pulses during busy are ignored.
